// File: rtl/input_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_cond_pkg
// Brief    : Shared constants, cycle helper and edge record for input_conditioner.
// Revision : 1.0 - initial release
// ============================================================================
package input_cond_pkg;

    localparam int CLK_HZ = 50_000_000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DB_CYCLES_DEF   = ms_to_cycles(10);
    localparam int LONG_CYCLES_DEF = ms_to_cycles(2000);

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } edge_t;

endpackage
`default_nettype wire

// File: rtl/input_conditioner_debounce_cell.sv
`default_nettype none
// ============================================================================
// Module   : debounce_cell
// Brief    : 2-flop synchroniser, stability counter and registered rise/fall.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_cell #(
    parameter int   DB_CYCLES = 4,
    parameter logic INVERT    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int                 c_cnt_w    = $clog2(DB_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_stable;
    logic               r_rise;
    logic               r_fall;
    logic               w_sample;

    // Synchroniser resets to the pad level that means "released".
    assign w_sample = r_sync ^ INVERT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= INVERT;
            r_sync   <= INVERT;
            r_cnt    <= '0;
            r_stable <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_meta <= raw;
            r_sync <= r_meta;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_sample == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_stable <= w_sample;
                r_cnt    <= '0;
                r_rise   <= w_sample;
                r_fall   <= ~w_sample;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_stable;
    assign rise  = r_rise;
    assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Brief    : Debounced switches plus play button with press handshake.
//            Define INPUT_COND_LONG_PRESS_EN to build the long-press detector.
// Revision : 1.0 - initial release
// ============================================================================
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int N_SW           = 3,
    parameter int DB_CYCLES      = DB_CYCLES_DEF,
    parameter int BTN_ACTIVE_LOW = 1,
    parameter int LONG_CYCLES    = LONG_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_SW-1:0] sw_raw,
    input  logic            btn_raw,
    input  logic            pend_ack,
    output logic [N_SW-1:0] sw_db,
    output logic            btn_db,
    output logic            btn_press,
    output logic            btn_release,
    output logic            btn_pending,
    output logic            press_ovf,
    output logic            btn_long
);

    logic [N_SW:0] w_raw;
    logic [N_SW:0] w_level;
    logic [N_SW:0] w_rise;
    logic [N_SW:0] w_fall;
    edge_t         w_btn;
    logic          w_unused_sw_edges;
    logic          r_pending;
    logic          r_ovf;

    // Channel N_SW is the button; only it is polarity-corrected.
    assign w_raw = {btn_raw, sw_raw};

    for (genvar i = 0; i <= N_SW; i++) begin : g_chan
        debounce_cell #(
            .DB_CYCLES (DB_CYCLES),
            .INVERT    ((i == N_SW) && (BTN_ACTIVE_LOW != 0))
        ) u_cell (
            .clk   (clk),
            .reset (reset),
            .raw   (w_raw[i]),
            .level (w_level[i]),
            .rise  (w_rise[i]),
            .fall  (w_fall[i])
        );
    end

    assign w_btn             = {w_level[N_SW], w_rise[N_SW], w_fall[N_SW]};
    assign w_unused_sw_edges = ^{w_rise[N_SW-1:0], w_fall[N_SW-1:0]};

    // A press in the same cycle as an ack wins, so it is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_btn.rise)
                r_pending <= 1'b1;
            else if (pend_ack)
                r_pending <= 1'b0;

            if (w_btn.rise && r_pending && !pend_ack)
                r_ovf <= 1'b1;
            else if (pend_ack)
                r_ovf <= 1'b0;
        end
    end

`ifdef INPUT_COND_LONG_PRESS_EN
    localparam int                  c_hold_w    = $clog2(LONG_CYCLES + 1);
    localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(LONG_CYCLES);
    localparam logic [c_hold_w-1:0] c_hold_fire = c_hold_w'(LONG_CYCLES - 1);

    logic [c_hold_w-1:0] r_hold;

    // Saturation keeps the pulse to a single one per press.
    always_ff @(posedge clk) begin
        if (reset || !w_btn.level)
            r_hold <= '0;
        else if (r_hold != c_hold_max)
            r_hold <= r_hold + 1'b1;
    end

    assign btn_long = w_btn.level && (r_hold == c_hold_fire);
`else
    localparam int c_unused_long_cycles = LONG_CYCLES;

    assign btn_long = 1'b0;
`endif

    assign sw_db       = w_level[N_SW-1:0];
    assign btn_db      = w_btn.level;
    assign btn_press   = w_btn.rise;
    assign btn_release = w_btn.fall;
    assign btn_pending = r_pending;
    assign press_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Brief    : Directed self-checking bench, DB_CYCLES=4, LONG_CYCLES=20.
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    localparam int c_n_sw = 3;
    localparam int c_db   = 4;
    localparam int c_long = 20;
`ifdef INPUT_COND_LONG_PRESS_EN
    localparam int c_long_on = 1;
`else
    localparam int c_long_on = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [c_n_sw-1:0] sw_raw;
    logic              btn_raw;
    logic              pend_ack;
    logic [c_n_sw-1:0] sw_db;
    logic              btn_db;
    logic              btn_press;
    logic              btn_release;
    logic              btn_pending;
    logic              press_ovf;
    logic              btn_long;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_conditioner #(
        .N_SW           (c_n_sw),
        .DB_CYCLES      (c_db),
        .BTN_ACTIVE_LOW (1),
        .LONG_CYCLES    (c_long)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sw_raw      (sw_raw),
        .btn_raw     (btn_raw),
        .pend_ack    (pend_ack),
        .sw_db       (sw_db),
        .btn_db      (btn_db),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_pending (btn_pending),
        .press_ovf   (press_ovf),
        .btn_long    (btn_long)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        reset = 1'b1; btn_raw = 1'b1; sw_raw = '0; pend_ack = 1'b0;
        repeat (3) step();
        obs = {sw_db, btn_db, btn_press, btn_release, btn_pending, press_ovf, btn_long};
        checks++;
        if (obs !== 9'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", obs, 9'h0);
        end
        reset = 1'b0;
        repeat (8) step();
        checks++;
        if (btn_db !== 1'b0 || btn_pending !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got db=%b pend=%b expected 0 0", btn_db, btn_pending);
        end
    endtask

    task automatic test_switches();
        sw_raw = 3'b101;
        repeat (c_db + 1) step();
        checks++;
        if (sw_db !== 3'b000) begin
            failures++;
            $display("FAIL sw_early: got %b expected %b", sw_db, 3'b000);
        end
        step();
        checks++;
        if (sw_db !== 3'b101) begin
            failures++;
            $display("FAIL sw_latency: got %b expected %b", sw_db, 3'b101);
        end
        sw_raw = 3'b010;
        repeat (c_db + 2) step();
        checks++;
        if (sw_db !== 3'b010) begin
            failures++;
            $display("FAIL sw_change: got %b expected %b", sw_db, 3'b010);
        end
    endtask

    task automatic test_press();
        btn_raw = 1'b0;
        repeat (c_db + 1) step();
        checks++;
        if (btn_db !== 1'b0 || btn_press !== 1'b0) begin
            failures++;
            $display("FAIL press_early: got db=%b press=%b expected 0 0", btn_db, btn_press);
        end
        step();
        checks++;
        if ({btn_db, btn_press, btn_pending} !== 3'b110) begin
            failures++;
            $display("FAIL press_edge: got %b expected %b", {btn_db, btn_press, btn_pending}, 3'b110);
        end
        step();
        checks++;
        if ({btn_db, btn_press, btn_pending} !== 3'b101) begin
            failures++;
            $display("FAIL press_after: got %b expected %b", {btn_db, btn_press, btn_pending}, 3'b101);
        end
        btn_raw = 1'b1;
        repeat (c_db + 1) step();
        checks++;
        if (btn_db !== 1'b1 || btn_release !== 1'b0) begin
            failures++;
            $display("FAIL release_early: got db=%b rel=%b expected 1 0", btn_db, btn_release);
        end
        step();
        checks++;
        if ({btn_db, btn_release} !== 2'b01) begin
            failures++;
            $display("FAIL release_edge: got %b expected %b", {btn_db, btn_release}, 2'b01);
        end
        pend_ack = 1'b1;
        step();
        pend_ack = 1'b0;
        checks++;
        if (btn_pending !== 1'b0 || btn_release !== 1'b0) begin
            failures++;
            $display("FAIL ack_clear: got pend=%b rel=%b expected 0 0", btn_pending, btn_release);
        end
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        for (int r = 0; r < 5; r++) begin
            btn_raw = 1'b0;
            for (int k = 0; k < 3; k++) begin
                step();
                seen |= btn_db | btn_press | btn_pending;
            end
            btn_raw = 1'b1;
            step();
            seen |= btn_db | btn_press | btn_pending;
        end
        repeat (8) begin
            step();
            seen |= btn_db | btn_press | btn_pending;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL glitch_reject: got activity=%b expected 0", seen);
        end
    endtask

    task automatic clean_press();
        btn_raw = 1'b0;
        repeat (c_db + 4) step();
        btn_raw = 1'b1;
        repeat (c_db + 4) step();
    endtask

    task automatic test_overflow();
        clean_press();
        checks++;
        if ({btn_pending, press_ovf} !== 2'b10) begin
            failures++;
            $display("FAIL ovf_first: got %b expected %b", {btn_pending, press_ovf}, 2'b10);
        end
        clean_press();
        checks++;
        if ({btn_pending, press_ovf} !== 2'b11) begin
            failures++;
            $display("FAIL ovf_second: got %b expected %b", {btn_pending, press_ovf}, 2'b11);
        end
        pend_ack = 1'b1;
        step();
        pend_ack = 1'b0;
        checks++;
        if ({btn_pending, press_ovf} !== 2'b00) begin
            failures++;
            $display("FAIL ovf_ack: got %b expected %b", {btn_pending, press_ovf}, 2'b00);
        end
    endtask

    task automatic test_ack_coincide();
        clean_press();
        pend_ack = 1'b1;
        btn_raw  = 1'b0;
        repeat (c_db + 2) step();
        checks++;
        if (btn_press !== 1'b1) begin
            failures++;
            $display("FAIL coincide_press: got %b expected 1", btn_press);
        end
        step();
        pend_ack = 1'b0;
        checks++;
        if ({btn_pending, press_ovf} !== 2'b10) begin
            failures++;
            $display("FAIL coincide_keep: got %b expected %b", {btn_pending, press_ovf}, 2'b10);
        end
        btn_raw = 1'b1;
        repeat (c_db + 4) step();
        pend_ack = 1'b1;
        step();
        pend_ack = 1'b0;
        checks++;
        if (btn_pending !== 1'b0) begin
            failures++;
            $display("FAIL coincide_clear: got %b expected 0", btn_pending);
        end
    endtask

    task automatic hold_and_count(input int release_at, input int span,
                                  output int pulses, output int first_idx, output logic timed_out);
        int n = 0;
        pulses = 0; first_idx = -1; timed_out = 1'b0;
        btn_raw = 1'b0;
        while (btn_db !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        if (btn_db !== 1'b1) timed_out = 1'b1;
        for (int idx = 0; idx <= span; idx++) begin
            if (idx == release_at) btn_raw = 1'b1;
            if (btn_long === 1'b1) begin
                if (pulses == 0) first_idx = idx;
                pulses++;
            end
            if (idx < span) step();
        end
        btn_raw = 1'b1;
        repeat (c_db + 4) step();
    endtask

    task automatic test_long();
        int   pulses;
        int   first_idx;
        logic to;
        hold_and_count(30, 30, pulses, first_idx, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL long_wait: btn_db never rose within 20 cycles");
        end
        checks++;
        if (pulses != c_long_on) begin
            failures++;
            $display("FAIL long_count: got %0d expected %0d", pulses, c_long_on);
        end
        if (c_long_on != 0) begin
            checks++;
            if (first_idx != c_long - 1) begin
                failures++;
                $display("FAIL long_timing: got idx %0d expected %0d", first_idx, c_long - 1);
            end
        end
        hold_and_count(15 - (c_db + 2), 25, pulses, first_idx, to);
        checks++;
        if (to || pulses != 0) begin
            failures++;
            $display("FAIL long_short_hold: got %0d pulses timeout=%b expected 0", pulses, to);
        end
        pend_ack = 1'b1;
        step();
        pend_ack = 1'b0;
    endtask

    task automatic test_mid_reset();
        btn_raw = 1'b0;
        repeat (c_db) step();
        reset = 1'b1;
        btn_raw = 1'b1;
        step();
        reset = 1'b0;
        repeat (c_db + 4) step();
        checks++;
        if ({btn_db, btn_pending} !== 2'b00) begin
            failures++;
            $display("FAIL mid_reset: got %b expected %b", {btn_db, btn_pending}, 2'b00);
        end
    endtask

    initial begin
        test_reset();
        test_switches();
        test_press();
        test_glitch();
        test_overflow();
        test_ack_coincide();
        test_long();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
